microwave_countdown_timer: RTL and testbench
============================================

Name: microwave_countdown_timer

Overview:
- Cook-time entry and countdown core of the microwave controller.
- Accepts keypad digits and shifts them into a BCD M:SS time, then counts down once per second while cooking. Handles door interlock, pause/resume and completion.
- Its three BCD outputs drive the seven-segment display stage directly. It also drives the magnetron enable and a done indication.

Parameters:
- CLK_HZ, 25_000_000, clock cycles per second; sets the 1 s tick period. Benches use 4.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- digit  in  4  keypad digit value
- digit_valid  in  1  one-cycle strobe: digit is present
- start  in  1  one-cycle start/resume strobe
- stop_clear  in  1  one-cycle stop/clear strobe
- door_closed  in  1  door interlock; 1 = closed (already synchronised)
- seconds_ones  out  4  BCD seconds units, 0-9
- seconds_tens  out  4  BCD seconds tens, 0-5 while counting
- minutes  out  4  BCD minutes, 0-9
- magnetron_on  out  1  high only in COOK
- done  out  1  high while in DONE
- done_pulse  out  1  one-cycle pulse on entry to DONE

Behaviour:
- Clock, reset and registers:
  - One clock (clk).
  - Reset is synchronous, active-low (rst_n sampled on rising clk edge).
  - All outputs are registered.
  - On reset: state=IDLE, time=0:00, tick counter=0, magnetron_on=0, done=0, done_pulse=0.
- States: IDLE, COOK, PAUSE, DONE.
- IDLE:
  - digit_valid with digit<=9 shifts the time left: minutes<=seconds_tens, seconds_tens<=seconds_ones, seconds_ones<=digit. The old minutes digit is lost.
  - digit>9 is ignored.
  - stop_clear sets the time to 0:00.
  - start moves to COOK only if all of these hold: door_closed=1, time!=0:00, seconds_tens<=5. Otherwise start is ignored and the state stays IDLE.
  - Entering COOK clears the tick counter.
- COOK:
  - Tick counter counts 0..CLK_HZ-1. At CLK_HZ-1 it wraps to 0 and the time decrements by 1 s in BCD.
  - Borrow rules: ones 0 becomes 9 with a borrow from tens; tens 0 becomes 5 with a borrow from minutes.
  - The first decrement is visible CLK_HZ cycles after the start strobe cycle.
  - When the decrement yields 0:00: next state is DONE, done_pulse=1 for one cycle, magnetron_on drops in the same cycle the display shows 0:00.
  - door_closed=0 moves to PAUSE. If a tick coincides, the decrement is suppressed and the counter holds its value.
  - stop_clear moves to PAUSE.
  - digit_valid is ignored.
- PAUSE:
  - Time and tick counter are held, so the partial second is preserved.
  - start with door_closed=1 returns to COOK without clearing the counter.
  - stop_clear moves to IDLE and clears the time to 0:00.
  - digit_valid is ignored.
- DONE:
  - Time reads 0:00 and done=1.
  - start, stop_clear, a digit_valid strobe or door_closed=0 moves to IDLE and clears done. That event is consumed and not also acted on in IDLE.
- Priority in the same cycle: stop_clear > door open > start > digit_valid > tick.
- Reset mid-operation: returns to IDLE within one cycle; magnetron_on=0 on the next edge.

Optional Feature:
- Macro: QUICK_START_EN.
- With the macro defined:
  - start in IDLE with time=0:00 and door_closed=1 loads 0:30 and enters COOK.
  - start while in COOK adds 30 s. In BCD: tens+3; if the result >5, subtract 6 and carry into minutes.
  - The added value saturates at 9:59.
  - The tick counter is not disturbed.
- Without the macro: start at 0:00 is ignored, and start in COOK has no effect.

Test Plan (CLK_HZ=4):
- Reset then digits 1,3,0 -> display 1:30. Start with door closed -> magnetron_on=1 next cycle; 1:29 exactly 4 cycles after the start strobe; 1:00 then 0:59 across the minute borrow.
- Load 0:02 and start -> 0:01, then 0:00 with done_pulse high one cycle; done=1 and magnetron_on=0. A following stop_clear -> IDLE, done=0.
- Cook 0:10, open door 2 cycles into a second -> PAUSE, display frozen. Close door and start -> next decrement 2 cycles later.
- Digits 9,0 -> 0:90. Start -> ignored, stays IDLE, magnetron_on=0. Start with time=0:00 and door open -> ignored.
- stop_clear and start asserted in the same cycle during COOK -> PAUSE. stop_clear in PAUSE -> IDLE, 0:00. Reset asserted mid-COOK -> 0:00, IDLE.
- QUICK_START_EN: start at 0:00 -> 0:30 cooking. Start at 0:45 -> 1:15. Start at 9:45 -> 9:59.

Source files
------------

// File: rtl/microwave_countdown_timer.sv
// microwave_countdown_timer: keypad M:SS entry and 1 s BCD countdown with door interlock, pause and done.
// Optional QUICK_START_EN macro enables the +30 s quick-start on the start strobe.
module microwave_countdown_timer #(
  parameter int CLK_HZ = 25_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] digit,
  input  logic       digit_valid,
  input  logic       start,
  input  logic       stop_clear,
  input  logic       door_closed,
  output logic [3:0] seconds_ones,
  output logic [3:0] seconds_tens,
  output logic [3:0] minutes,
  output logic       magnetron_on,
  output logic       done,
  output logic       done_pulse
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] COOK  = 2'd1;
  localparam logic [1:0] PAUSE = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;
  localparam int TW = CLK_HZ > 1 ? $clog2(CLK_HZ) : 1;
  localparam logic [TW-1:0] TMAX = TW'(CLK_HZ - 1);
  logic [1:0] state_q, state_d;
  logic [3:0] ones_q, ones_d, tens_q, tens_d, min_q, min_d;
  logic [TW-1:0] tick_q, tick_d;
  logic mag_q, done_q, pulse_q;
  logic b0, b1, time_zero, dec_zero, tick_wrap;
  logic [3:0] dec_o, dec_t, dec_m;
  logic [TW-1:0] tick_inc;
  assign b0 = ones_q == 4'd0;
  assign b1 = b0 && tens_q == 4'd0;
  assign dec_o = b0 ? 4'd9 : ones_q - 4'd1;
  assign dec_t = b0 ? (tens_q == 4'd0 ? 4'd5 : tens_q - 4'd1) : tens_q;
  assign dec_m = b1 ? min_q - 4'd1 : min_q;
  assign dec_zero = dec_m == 4'd0 && dec_t == 4'd0 && dec_o == 4'd0;
  assign time_zero = min_q == 4'd0 && tens_q == 4'd0 && ones_q == 4'd0;
  assign tick_wrap = tick_q == TMAX;
  assign tick_inc = tick_wrap ? '0 : tick_q + 1'b1;
`ifdef QUICK_START_EN
  logic carry, sat;
  logic [3:0] add_o, add_t, add_m;
  // 30 s is tens+3; tens is always <=5 while cooking so a carry means tens-3 into minutes
  assign carry = tens_q + 4'd3 > 4'd5;
  assign sat = carry && min_q == 4'd9;
  assign add_o = sat ? 4'd9 : ones_q;
  assign add_t = sat ? 4'd5 : carry ? tens_q - 4'd3 : tens_q + 4'd3;
  assign add_m = carry && !sat ? min_q + 4'd1 : min_q;
`endif
  always_comb begin
    state_d = state_q;
    ones_d = ones_q;
    tens_d = tens_q;
    min_d = min_q;
    tick_d = tick_q;
    case (state_q)
      IDLE:
        if (stop_clear) begin
          {min_d, tens_d, ones_d} = '0;
        end else if (start && door_closed && !time_zero && tens_q <= 4'd5) begin
          state_d = COOK;
          tick_d = '0;
`ifdef QUICK_START_EN
        end else if (start && door_closed && time_zero) begin
          state_d = COOK;
          tick_d = '0;
          tens_d = 4'd3;
`endif
        end else if (digit_valid && digit <= 4'd9) begin
          min_d = tens_q;
          tens_d = ones_q;
          ones_d = digit;
        end
      COOK:
        if (stop_clear || !door_closed) begin
          state_d = PAUSE;
`ifdef QUICK_START_EN
        end else if (start) begin
          {min_d, tens_d, ones_d} = {add_m, add_t, add_o};
          tick_d = tick_inc;
`endif
        end else begin
          tick_d = tick_inc;
          if (tick_wrap) begin
            {min_d, tens_d, ones_d} = {dec_m, dec_t, dec_o};
            state_d = dec_zero ? DONE : COOK;
          end
        end
      PAUSE:
        if (stop_clear) begin
          state_d = IDLE;
          {min_d, tens_d, ones_d} = '0;
        end else if (start && door_closed) begin
          state_d = COOK;
        end
      default:
        state_d = (start || stop_clear || digit_valid || !door_closed) ? IDLE : DONE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ones_q <= '0;
      tens_q <= '0;
      min_q <= '0;
      tick_q <= '0;
      mag_q <= 1'b0;
      done_q <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ones_q <= ones_d;
      tens_q <= tens_d;
      min_q <= min_d;
      tick_q <= tick_d;
      mag_q <= state_d == COOK;
      done_q <= state_d == DONE;
      pulse_q <= state_d == DONE && state_q == COOK;
    end
  end
  assign seconds_ones = ones_q;
  assign seconds_tens = tens_q;
  assign minutes = min_q;
  assign magnetron_on = mag_q;
  assign done = done_q;
  assign done_pulse = pulse_q;
endmodule

// File: tb/tb_microwave_countdown_timer.sv
// tb_microwave_countdown_timer: directed stimulus with a cycle-stamped expectation queue checked by a monitor.
module tb_microwave_countdown_timer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0] digit = '0;
  logic digit_valid = 1'b0, start = 1'b0, stop_clear = 1'b0, door_closed = 1'b1;
  logic [3:0] seconds_ones, seconds_tens, minutes;
  logic magnetron_on, done, done_pulse;
  typedef struct {
    int cyc;
    string nm;
    logic [14:0] v;
  } exp_t;
  exp_t sb[$];
  exp_t e;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  microwave_countdown_timer #(.CLK_HZ(4)) dut (
    .clk(clk), .rst_n(rst_n), .digit(digit), .digit_valid(digit_valid),
    .start(start), .stop_clear(stop_clear), .door_closed(door_closed),
    .seconds_ones(seconds_ones), .seconds_tens(seconds_tens), .minutes(minutes),
    .magnetron_on(magnetron_on), .done(done), .done_pulse(done_pulse)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // expected values are tagged with the cycle they belong to; the monitor compares them mid-cycle
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      checks++;
      if (e.cyc != cyc) begin
        errors++;
        $display("FAIL %s: missed at cycle %0d (now %0d)", e.nm, e.cyc, cyc);
      end else if ({minutes, seconds_tens, seconds_ones, magnetron_on, done, done_pulse} !== e.v) begin
        errors++;
        $display("FAIL %s: got %0h:%0h%0h mag=%b done=%b pulse=%b, want %0h:%0h%0h mag=%b done=%b pulse=%b",
                 e.nm, minutes, seconds_tens, seconds_ones, magnetron_on, done, done_pulse,
                 e.v[14:11], e.v[10:7], e.v[6:3], e.v[2], e.v[1], e.v[0]);
      end
    end
  end
  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic exp(input string nm, input logic [3:0] m, input logic [3:0] t, input logic [3:0] o,
                     input logic mag, input logic dn, input logic dp);
    exp_t x;
    x.cyc = cyc;
    x.nm = nm;
    x.v = {m, t, o, mag, dn, dp};
    sb.push_back(x);
  endtask
  task automatic press(input logic [3:0] d);
    digit = d;
    digit_valid = 1'b1;
    step();
    digit_valid = 1'b0;
  endtask
  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask
  task automatic pulse_stop();
    stop_clear = 1'b1;
    step();
    stop_clear = 1'b0;
  endtask
  initial begin
    step(2);
    exp("reset", 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    step();
    press(1); press(3); press(0);
    exp("entry_130", 1, 3, 0, 0, 0, 0);
    pulse_start();
    exp("start_mag", 1, 3, 0, 1, 0, 0);
    step(3);
    exp("pre_tick", 1, 3, 0, 1, 0, 0);
    step();
    exp("first_dec", 1, 2, 9, 1, 0, 0);
    step(29 * 4);
    exp("at_100", 1, 0, 0, 1, 0, 0);
    step(4);
    exp("min_borrow", 0, 5, 9, 1, 0, 0);
    pulse_stop();
    exp("cook_stop", 0, 5, 9, 0, 0, 0);
    pulse_stop();
    exp("pause_clear", 0, 0, 0, 0, 0, 0);
    press(2);
    pulse_start();
    exp("start_002", 0, 0, 2, 1, 0, 0);
    step(4);
    exp("dec_001", 0, 0, 1, 1, 0, 0);
    step(3);
    exp("hold_001", 0, 0, 1, 1, 0, 0);
    step();
    exp("done_entry", 0, 0, 0, 0, 1, 1);
    step();
    exp("done_hold", 0, 0, 0, 0, 1, 0);
    pulse_stop();
    exp("done_exit", 0, 0, 0, 0, 0, 0);
    press(5);
    exp("idle_after_done", 0, 0, 5, 0, 0, 0);
    pulse_stop();
    press(1); press(0);
    exp("entry_010", 0, 1, 0, 0, 0, 0);
    pulse_start();
    step(2);
    door_closed = 1'b0;
    step();
    exp("door_pause", 0, 1, 0, 0, 0, 0);
    step(6);
    exp("pause_frozen", 0, 1, 0, 0, 0, 0);
    door_closed = 1'b1;
    pulse_start();
    exp("resume", 0, 1, 0, 1, 0, 0);
    step();
    exp("resume_hold", 0, 1, 0, 1, 0, 0);
    step();
    exp("resume_dec", 0, 0, 9, 1, 0, 0);
    stop_clear = 1'b1;
    start = 1'b1;
    step();
    stop_clear = 1'b0;
    start = 1'b0;
    exp("stop_over_start", 0, 0, 9, 0, 0, 0);
    pulse_stop();
    exp("pause_to_idle", 0, 0, 0, 0, 0, 0);
    press(9); press(0);
    exp("entry_090", 0, 9, 0, 0, 0, 0);
    pulse_start();
    exp("bad_tens_start", 0, 9, 0, 0, 0, 0);
    pulse_stop();
    door_closed = 1'b0;
    pulse_start();
    exp("door_open_start", 0, 0, 0, 0, 0, 0);
    door_closed = 1'b1;
`ifndef QUICK_START_EN
    pulse_start();
    exp("zero_start", 0, 0, 0, 0, 0, 0);
`endif
    press(7);
    press(4'd12);
    exp("digit_gt9", 0, 0, 7, 0, 0, 0);
    pulse_start();
    press(3);
    exp("digit_in_cook", 0, 0, 7, 1, 0, 0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    exp("mid_reset", 0, 0, 0, 0, 0, 0);
`ifdef QUICK_START_EN
    pulse_start();
    exp("quick_030", 0, 3, 0, 1, 0, 0);
    pulse_start();
    exp("quick_100", 1, 0, 0, 1, 0, 0);
    pulse_stop(); pulse_stop();
    press(4); press(5);
    pulse_start();
    pulse_start();
    exp("quick_115", 1, 1, 5, 1, 0, 0);
    pulse_stop(); pulse_stop();
    press(9); press(4); press(5);
    pulse_start();
    pulse_start();
    exp("quick_sat", 9, 5, 9, 1, 0, 0);
    pulse_stop(); pulse_stop();
`endif
    step(2);
    if (sb.size() > 0) begin
      $display("FAIL leftover: %0d expectations unchecked, want 0", sb.size());
      errors += sb.size();
      checks += sb.size();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
